// File: rtl/div_unit_if.sv
// Request/response bus of the RV32M divide unit: the request carries the
// operation and operands, the response carries the 32-bit result.
interface div_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  divop;
    logic [31:0] a;
    logic [31:0] b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] f;

    modport master (
        output req_valid, divop, a, b, resp_ready,
        input  req_ready, resp_valid, f
    );

    modport slave (
        input  req_valid, divop, a, b, resp_ready,
        output req_ready, resp_valid, f
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU/REM/REMU unit: radix-2 restoring division, one quotient
// bit per clock, with divide-by-zero and signed overflow resolved in one cycle.
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    div_unit_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  op_q;
    logic        neg_q;
    logic        spec_q;
    logic [4:0]  cnt;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic [31:0] f_q;

    logic        signed_op, a_neg, b_neg, div_zero, ovf;
    logic [31:0] a_mag, b_mag, special_res;
    logic [32:0] partial;
    logic        ge;
    logic [31:0] diff, rem_nxt, quo_nxt, res_raw, result;

    // NOTE: every signal written here gets a default first, so no path can leave
    // a value unassigned and infer a latch.
    always_comb begin
        signed_op   = ~bus.divop[0];
        a_neg       = signed_op & bus.a[31];
        b_neg       = signed_op & bus.b[31];
        a_mag       = a_neg ? (32'd0 - bus.a) : bus.a;
        b_mag       = b_neg ? (32'd0 - bus.b) : bus.b;
        div_zero    = (bus.b == 32'd0);
        ovf         = signed_op && (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
        special_res = 32'd0;
        if (div_zero)
            special_res = bus.divop[1] ? bus.a : 32'hFFFF_FFFF;
        else if (ovf)
            special_res = bus.divop[1] ? 32'd0 : 32'h8000_0000;

        // Shift the next dividend bit into the remainder and trial-subtract.
        // When the subtraction succeeds the true difference is below the
        // divisor, so its low 32 bits are exact.
        partial = {rem_q, quo_q[31]};
        ge      = (partial >= {1'b0, dvs_q});
        diff    = partial[31:0] - dvs_q;
        rem_nxt = ge ? diff : partial[31:0];
        quo_nxt = {quo_q[30:0], ge};
        res_raw = op_q[1] ? rem_nxt : quo_nxt;
        result  = neg_q ? (32'd0 - res_raw) : res_raw;
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = (state == S_DONE);
    assign bus.f          = f_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= 2'd0;
            neg_q  <= 1'b0;
            spec_q <= 1'b0;
            cnt    <= 5'd0;
            quo_q  <= 32'd0;
            rem_q  <= 32'd0;
            dvs_q  <= 32'd0;
            f_q    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        state <= S_CALC;
                        op_q  <= bus.divop;
                        cnt   <= 5'd0;
                        rem_q <= 32'd0;
                        dvs_q <= b_mag;
                        neg_q <= bus.divop[1] ? a_neg : (a_neg ^ b_neg);
                        // Special cases park their answer in the quotient
                        // register and spend exactly one CALC cycle.
                        spec_q <= div_zero | ovf;
                        quo_q  <= (div_zero | ovf) ? special_res : a_mag;
                    end
                end
                S_CALC: begin
                    if (spec_q) begin
                        f_q   <= quo_q;
                        state <= S_DONE;
                    end else begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            f_q   <= result;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed vectors, latency, backpressure,
// mid-operation reset and a corner-value sweep against a reference model.
module tb_div_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    div_unit_if bus ();

    div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx, sy;
        sx = x;
        sy = y;
        if (y == 32'd0)
            return op[1] ? x : 32'hFFFF_FFFF;
        if (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return sx / sy;
            2'b01:   return x / y;
            2'b10:   return sx % sy;
            default: return x % y;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 1;
        if (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 32;
    endfunction

    // Issues one request at posedge+1 and returns at posedge+1 after the
    // response handshake; operands are scrambled while the unit is busy.
    task automatic run(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int exp_lat, input int stall, input string tag);
        int lat;
        logic [31:0] held;
        check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.resp_ready = (stall == 0);
        bus.req_valid  = 1'b1;
        bus.divop      = op;
        bus.a          = x;
        bus.b          = y;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.divop      = 2'($urandom);
        bus.a          = $urandom;
        bus.b          = $urandom;
        lat = 0;
        while (!bus.resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/f"}, bus.f, exp);
        held = bus.f;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, "/stall_hold"}, {bus.resp_valid, bus.req_ready, bus.f}, {1'b1, 1'b0, held});
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "/back_to_idle"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
    endtask

    logic [31:0] vals [5];
    int          seen;

    initial begin
        checks = 0;
        errors = 0;
        vals   = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        bus.divop      = 2'b00;
        bus.a          = 32'd0;
        bus.b          = 32'd0;
        #1;
        check("reset/f", bus.f, 32'd0);
        check("reset/resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset/req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unsigned and signed directed vectors.
        run(2'b01, 32'd100, 32'd7, 32'd14, 32, 0, "divu_100_7");
        run(2'b11, 32'd100, 32'd7, 32'd2, 32, 0, "remu_100_7");
        run(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, 0, "div_m7_2");
        run(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, 0, "rem_m7_2");
        run(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, 0, "div_7_m2");
        run(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32, 0, "rem_7_m2");

        // Divide-by-zero and signed overflow.
        run(2'b00, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 0, "div_by0");
        run(2'b01, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 0, "divu_by0");
        run(2'b10, 32'h0000_1234, 32'd0, 32'h0000_1234, 1, 0, "rem_by0");
        run(2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 1, 0, "remu_by0");
        run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, "rem_ovf");
        run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32, 0, "divu_ovf_operands");

        // Backpressure: result held for 5 cycles, a stray request is ignored.
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.divop      = 2'b01;
        bus.a          = 32'd100;
        bus.b          = 32'd7;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        seen = 0;
        while (!bus.resp_valid && seen < 40) begin
            @(posedge clk); #1;
            seen++;
        end
        check("bp/latency", 32'(seen), 32'd32);
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = (i == 2);
            bus.divop     = 2'b00;
            bus.a         = 32'd5;
            bus.b         = 32'd1;
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            check("bp/hold", {bus.resp_valid, bus.req_ready, bus.f}, {1'b1, 1'b0, 32'd14});
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp/released", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) seen++;
        end
        check("bp/stray_req_ignored", 32'(seen), 32'd0);

        // Reset during CALC iteration 10 discards the operation.
        bus.req_valid = 1'b1;
        bus.divop     = 2'b01;
        bus.a         = 32'd1000;
        bus.b         = 32'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midcalc/busy", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midcalc_rst/f", bus.f, 32'd0);
        check("midcalc_rst/resp_valid", 32'(bus.resp_valid), 32'd0);
        check("midcalc_rst/req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) seen++;
        end
        check("midcalc_rst/no_response", 32'(seen), 32'd0);

        // Corner-value sweep, back to back, with random response stalls.
        for (int op = 0; op < 4; op++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    run(2'(op), vals[i], vals[j], model(2'(op), vals[i], vals[j]),
                        model_lat(2'(op), vals[i], vals[j]), int'($urandom_range(0, 3)),
                        $sformatf("sweep_op%0d_%0d_%0d", op, i, j));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
